add_sub_result_stage: RTL

//  Registered output stage directly downstream of the combinational 4-bit add/sub unit.

---
 rtl/add_sub_pkg.sv | 36 +++
 rtl/add_sub_skid_fifo.sv | 64 ++++++
 rtl/add_sub_result_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/sub result stage: flag bit positions,
// the packed flag struct and the flag-derivation function.
package add_sub_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Field order gives {V,C,N,Z} with Z in bit 0.
    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } addsub_flags_t;

    // Flags come from the adder outputs plus the operand sign bits. B's sign
    // is taken before the subtract inversion, so the V rule depends on a_s.
    function automatic addsub_flags_t calc_flags(
        input logic sum_zero,
        input logic sum_msb,
        input logic cout,
        input logic a_s,
        input logic a_msb,
        input logic b_msb
    );
        addsub_flags_t f;
        f.z = sum_zero;
        f.n = sum_msb;
        f.c = a_s ? ~cout : cout;
        f.v = (a_s ? (a_msb != b_msb) : (a_msb == b_msb)) & (sum_msb != a_msb);
        return f;
    endfunction

endpackage

// File: rtl/add_sub_skid_fifo.sv
// Two-entry in-order buffer built from a head and a tail register.
// The head register drives the outputs directly. in_ready depends only on
// the registered occupancy, so out_ready never reaches in_ready combinationally.
module add_sub_skid_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    import add_sub_pkg::*;

    logic [1:0]    count_q, count_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state: head and tail shift on pop; push fills the first free slot.
    // After a pop that empties the buffer the head keeps its last value.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data;
                else                 tail_d = in_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            // Only reachable at count=1: the old head leaves and the new entry replaces it.
            2'b11: head_d = in_data;
            default: ;
        endcase
    end

    // Occupancy and storage registers; reset flushes everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/add_sub_result_stage.sv
// Registered result stage behind the combinational 4-bit add/sub unit.
// Derives Z/N/C/V at push time and buffers {flags, sum} in a 2-entry FIFO.
// Optional macro ADDSUB_STATS_EN adds saturating op/overflow counters.
module add_sub_result_stage
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             a_s,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
`ifdef ADDSUB_STATS_EN
    ,
    output logic [CNT_W-1:0] ovf_count,
    output logic [CNT_W-1:0] op_count
`endif
);

    // Reject configurations the datapath cannot represent.
    if (WIDTH < 2) begin : g_bad_width
        $error("add_sub_result_stage: WIDTH must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("add_sub_result_stage: CNT_W must be at least 1");
    end

    localparam int PW = WIDTH + 4;

    addsub_flags_t   flags_in;
    logic [PW-1:0]   fifo_in, fifo_out;
    logic            push;

    assign flags_in = calc_flags((sum == '0), sum[WIDTH-1], cout, a_s, a_msb, b_msb);
    assign fifo_in  = {flags_in, sum};
    assign push     = in_valid & in_ready;

    add_sub_skid_fifo #(.DW(PW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (fifo_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out)
    );

    assign out_result = fifo_out[WIDTH-1:0];
    assign out_flags  = fifo_out[PW-1:WIDTH];

`ifdef ADDSUB_STATS_EN
    logic [CNT_W-1:0] op_q, op_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    // Counters advance on accepted pushes and stick at all-ones.
    always_comb begin
        op_d  = op_q;
        ovf_d = ovf_q;
        if (push) begin
            if (op_q != '1) op_d = op_q + 1'b1;
            if (flags_in.v && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
        end
    end

    // Statistic registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            ovf_q <= '0;
        end else begin
            op_q  <= op_d;
            ovf_q <= ovf_d;
        end
    end

    assign op_count  = op_q;
    assign ovf_count = ovf_q;
`endif

endmodule
